// File: rtl/bcd_cascade_counter_if.sv
// Control/status bundle for bcd_cascade_counter: step, clear and preset strobes in,
// registered digits and terminal-count flags out.
interface bcd_cascade_counter_if #(
  parameter int DIGITS = 6
);
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  inc;
  logic                  dec;
  logic [4*DIGITS-1:0]   q;
  logic [DIGITS-1:0]     digit_tc;
  logic                  tc;
  logic                  zero;

  modport master (
    output clr, load, load_val, inc, dec,
    input  q, digit_tc, tc, zero
  );

  modport slave (
    input  clr, load, load_val, inc, dec,
    output q, digit_tc, tc, zero
  );
endinterface

// File: rtl/bcd_cascade_counter.sv
// Chain of mixed-modulus BCD digits with combinational carry/borrow ripple.
// Define BCC_SATURATE_EN to block the full-chain wrap (q holds, tc still pulses).
module bcd_cascade_counter #(
  parameter int                  DIGITS  = 6,
  parameter logic [4*DIGITS-1:0] MOD_VEC = 24'h6A6AAA
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_cascade_counter_if.slave bus
);

  typedef enum logic [1:0] {
    DIR_HOLD,
    DIR_UP,
    DIR_DOWN
  } dir_e;

  logic [4*DIGITS-1:0] q_r;
  logic [4*DIGITS-1:0] step_q;
  logic [4*DIGITS-1:0] load_q;
  logic [DIGITS-1:0]   dtc;
  dir_e                dir;

  // Stepping is suppressed in any cycle where rst, clr or load wins priority,
  // so no carry flag can escape from a cycle that does not step.
  always_comb begin
    dir = DIR_HOLD;
    if (!rst && !bus.clr && !bus.load) begin
      if (bus.inc && !bus.dec)      dir = DIR_UP;
      else if (bus.dec && !bus.inc) dir = DIR_DOWN;
    end
  end

  always_comb begin
    logic       carry;
    logic [3:0] digit;
    logic [3:0] mod_i;
    logic [3:0] mod_m1;
    logic       at_term;
    // NOTE: every variable gets a value before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    step_q  = q_r;
    load_q  = '0;
    dtc     = '0;
    carry   = (dir != DIR_HOLD);
    digit   = '0;
    mod_i   = '0;
    mod_m1  = '0;
    at_term = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      digit   = q_r[4*i +: 4];
      mod_i   = MOD_VEC[4*i +: 4];
      mod_m1  = mod_i - 4'd1;
      at_term = (dir == DIR_DOWN) ? (digit == 4'd0) : (digit == mod_m1);
      dtc[i]  = carry & at_term;
      if (carry) begin
        if (dir == DIR_DOWN) step_q[4*i +: 4] = at_term ? mod_m1 : digit - 4'd1;
        else                 step_q[4*i +: 4] = at_term ? 4'd0   : digit + 4'd1;
      end
      carry = dtc[i];
      // Out-of-range preset nibbles clamp to the digit's top value.
      load_q[4*i +: 4] = (bus.load_val[4*i +: 4] >= mod_i) ? mod_m1 : bus.load_val[4*i +: 4];
    end
`ifdef BCC_SATURATE_EN
    if (dtc[DIGITS-1]) step_q = q_r;
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst || bus.clr) q_r <= '0;
    else if (bus.load)  q_r <= load_q;
    else                q_r <= step_q;
  end

  assign bus.q        = q_r;
  assign bus.digit_tc = dtc;
  assign bus.tc       = dtc[DIGITS-1];
  assign bus.zero     = (q_r == '0);

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed bench for bcd_cascade_counter with default parameters; expectations
// follow BCC_SATURATE_EN when the build defines it.
module tb_bcd_cascade_counter;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  bcd_cascade_counter_if #(.DIGITS(6)) bus ();

  bcd_cascade_counter #(
    .DIGITS (6),
    .MOD_VEC(24'h6A6AAA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and q is sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change, well before the edge.
  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic c, input logic l, input logic [23:0] lv,
                       input logic i, input logic d);
    bus.clr      = c;
    bus.load     = l;
    bus.load_val = lv;
    bus.inc      = i;
    bus.dec      = d;
  endtask

  task automatic preset(input logic [23:0] v);
    drive(1'b0, 1'b1, v, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    settle();
  endtask

  initial begin
    // Reset held two cycles with inc high
    rst = 1'b1;
    drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_q",        bus.q,        32'h0);
      check("rst_zero",     bus.zero,     32'h1);
      check("rst_tc",       bus.tc,       32'h0);
      check("rst_digit_tc", bus.digit_tc, 32'h0);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    settle();

    // Ripple up through five digits
    preset(24'h095999);
    check("ripple_load_q", bus.q, 32'h095999);
    bus.inc = 1'b1;
    settle();
    check("ripple_digit_tc", bus.digit_tc, 32'h1F);
    check("ripple_tc",       bus.tc,       32'h0);
    tick();
    bus.inc = 1'b0;
    settle();
    check("ripple_q", bus.q, 32'h100000);

    // Borrow back down across the same digits
    bus.dec = 1'b1;
    settle();
    check("borrow_digit_tc", bus.digit_tc, 32'h1F);
    tick();
    bus.dec = 1'b0;
    settle();
    check("borrow_q", bus.q, 32'h095999);

    // Full wrap up
    preset(24'h595999);
    bus.inc = 1'b1;
    settle();
    check("wrap_up_tc",       bus.tc,       32'h1);
    check("wrap_up_digit_tc", bus.digit_tc, 32'h3F);
    tick();
    bus.inc = 1'b0;
    settle();
`ifdef BCC_SATURATE_EN
    check("wrap_up_q", bus.q, 32'h595999);
`else
    check("wrap_up_q", bus.q, 32'h0);
`endif
    check("wrap_up_tc_pulse_end", bus.tc, 32'h0);

    // Clear, then down wrap
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    settle();
    check("clr_q",    bus.q,    32'h0);
    check("clr_zero", bus.zero, 32'h1);
    bus.dec = 1'b1;
    settle();
    check("wrap_down_tc", bus.tc, 32'h1);
    tick();
    settle();
`ifdef BCC_SATURATE_EN
    check("wrap_down_q",  bus.q,  32'h0);
    check("wrap_down_tc2", bus.tc, 32'h1);
    tick();
    bus.dec = 1'b0;
    settle();
    check("wrap_down_q2", bus.q, 32'h0);
`else
    check("wrap_down_q",   bus.q,    32'h595999);
    check("wrap_down_zero", bus.zero, 32'h0);
    check("wrap_down_tc2", bus.tc,   32'h0);
    tick();
    bus.dec = 1'b0;
    settle();
    check("wrap_down_q2", bus.q, 32'h595998);
`endif

    // inc and dec together hold
    preset(24'h000009);
    drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
    settle();
    check("conflict_digit_tc", bus.digit_tc, 32'h0);
    tick();
    check("conflict_q", bus.q, 32'h000009);

    // Load beats inc, with per-digit clamping
    drive(1'b0, 1'b1, 24'hF0F0F0, 1'b1, 1'b0);
    settle();
    check("load_inc_digit_tc", bus.digit_tc, 32'h0);
    tick();
    drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    settle();
    check("load_clamp_q", bus.q, 32'h505090);

    // Clear beats load and inc
    preset(24'h123456);
    check("pre_clr_q",    bus.q,    32'h123456);
    check("pre_clr_zero", bus.zero, 32'h0);
    drive(1'b1, 1'b1, 24'h595999, 1'b1, 1'b0);
    settle();
    check("clr_pri_digit_tc", bus.digit_tc, 32'h0);
    tick();
    drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    settle();
    check("clr_pri_q",    bus.q,    32'h0);
    check("clr_pri_zero", bus.zero, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
